// File: rtl/instruction_memory_pkg.sv
// Shared constants for the instruction memory: sizes, halt opcode and the
// optional preload image selected by IMEM_PRELOAD_EN.
package instruction_memory_pkg;

  localparam int unsigned MEM_BYTES_DEFAULT = 1024;
  localparam int unsigned FETCH_BYTES       = 10;
  localparam logic [7:0]  OP_HALT           = 8'h00;

  // Preload image: irmovq $0x10,%rax (bytes 0..9) followed by halt (byte 10)
  localparam int unsigned PRELOAD_BYTES = 11;
  localparam logic [PRELOAD_BYTES-1:0][7:0] PRELOAD_IMAGE = {
    8'h00,                                   // byte 10: halt
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, // bytes 9..3
    8'h10, 8'hF0, 8'h30                      // bytes 2..0
  };

  // Byte of the preload image at a given address (halt beyond the image)
  function automatic logic [7:0] preload_byte(input int unsigned idx);
    logic [7:0] b;
    b = OP_HALT;
    if (idx < PRELOAD_BYTES) b = PRELOAD_IMAGE[4'(idx)];
    return b;
  endfunction

endpackage

// File: rtl/imem_storage.sv
// Byte array for the instruction memory: async reset to the reset image and
// a single byte write port. Reset image selected by IMEM_PRELOAD_EN.
module imem_storage
  import instruction_memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  mem_q [MEM_BYTES]
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;

  // Reset contents of one location
  function automatic logic [7:0] reset_byte(input int unsigned idx);
`ifdef IMEM_PRELOAD_EN
    return preload_byte(idx);
`else
    if (idx >= 0) return OP_HALT;
    return OP_HALT;
`endif
  endfunction

  logic wr_ok;
  assign wr_ok = wr_en && (wr_addr < 64'(MEM_BYTES));

  // Whole array reloads the image under reset; in-range writes only otherwise
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < MEM_BYTES; i++) begin
        mem_q[AW'(i)] <= reset_byte(i);
      end
    end else if (wr_ok) begin
      mem_q[wr_addr[AW-1:0]] <= wr_data;
    end
  end

endmodule

// File: rtl/instruction_memory.sv
// Instruction memory: combinational 10-byte little-endian fetch window at PC
// with range check; whole window reads as halt when any byte is out of range.
// Build option: IMEM_PRELOAD_EN selects the preloaded reset image.
module instruction_memory
  import instruction_memory_pkg::*;
#(
  parameter int unsigned MEM_BYTES = MEM_BYTES_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] PC,
  input  logic        wr_en,
  input  logic [63:0] wr_addr,
  input  logic [7:0]  wr_data,
  output logic [7:0]  im_out0,
  output logic [7:0]  im_out1,
  output logic [7:0]  im_out2,
  output logic [7:0]  im_out3,
  output logic [7:0]  im_out4,
  output logic [7:0]  im_out5,
  output logic [7:0]  im_out6,
  output logic [7:0]  im_out7,
  output logic [7:0]  im_out8,
  output logic [7:0]  im_out9,
  output logic        imem_error
);

  localparam int unsigned AW = (MEM_BYTES > 1) ? $clog2(MEM_BYTES) : 1;
  localparam int unsigned FW = $clog2(FETCH_BYTES);
  localparam logic [63:0] LAST_PC = 64'(MEM_BYTES - FETCH_BYTES);

  logic [7:0] mem_q [MEM_BYTES];
  logic [7:0] win   [FETCH_BYTES];
  logic [AW-1:0] rd_idx;

  imem_storage #(
    .MEM_BYTES (MEM_BYTES)
  ) u_storage (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .mem_q   (mem_q)
  );

  // Range check and masked fetch window; no wrap, full 64-bit compare
  always_comb begin
    imem_error = (PC > LAST_PC);
    rd_idx     = '0;
    for (int unsigned k = 0; k < FETCH_BYTES; k++) begin
      win[FW'(k)] = OP_HALT;
      rd_idx      = PC[AW-1:0] + AW'(k);
      if (!imem_error) win[FW'(k)] = mem_q[rd_idx];
    end
  end

  assign im_out0 = win[0];
  assign im_out1 = win[1];
  assign im_out2 = win[2];
  assign im_out3 = win[3];
  assign im_out4 = win[4];
  assign im_out5 = win[5];
  assign im_out6 = win[6];
  assign im_out7 = win[7];
  assign im_out8 = win[8];
  assign im_out9 = win[9];

endmodule

// File: tb/tb_instruction_memory.sv
// Self-checking bench for instruction_memory (MEM_BYTES = 1024).
module tb_instruction_memory;

  localparam int unsigned N = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] PC;
  logic        wr_en;
  logic [63:0] wr_addr;
  logic [7:0]  wr_data;
  logic [7:0]  im_out0, im_out1, im_out2, im_out3, im_out4;
  logic [7:0]  im_out5, im_out6, im_out7, im_out8, im_out9;
  logic        imem_error;

  logic [7:0]  o [10];
  logic [7:0]  model [N];
  int          errors = 0;
  int          checks = 0;

  instruction_memory #(.MEM_BYTES(N)) dut (
    .clk(clk), .rst_n(rst_n), .PC(PC),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .im_out0(im_out0), .im_out1(im_out1), .im_out2(im_out2), .im_out3(im_out3),
    .im_out4(im_out4), .im_out5(im_out5), .im_out6(im_out6), .im_out7(im_out7),
    .im_out8(im_out8), .im_out9(im_out9), .imem_error(imem_error)
  );

  assign o[0] = im_out0; assign o[1] = im_out1; assign o[2] = im_out2;
  assign o[3] = im_out3; assign o[4] = im_out4; assign o[5] = im_out5;
  assign o[6] = im_out6; assign o[7] = im_out7; assign o[8] = im_out8;
  assign o[9] = im_out9;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h (PC=%h)", tag, obs, exp, PC);
    end
  endtask

  // Reference image after reset
  task automatic model_reset();
    for (int i = 0; i < N; i++) model[i] = 8'h00;
`ifdef IMEM_PRELOAD_EN
    model[0] = 8'h30; model[1] = 8'hF0; model[2] = 8'h10;
`endif
  endtask

  // Compare the whole window for the current PC against the model
  task automatic compare_now();
    logic        exp_err;
    logic [63:0] a;
    logic [7:0]  e;
    exp_err = (PC > 64'(N - 10));
    chk("imem_error", 64'(imem_error), 64'(exp_err));
    for (int k = 0; k < 10; k++) begin
      a = PC + 64'(k);
      e = exp_err ? 8'h00 : model[a[9:0]];
      chk($sformatf("im_out%0d", k), 64'(o[k]), 64'(e));
    end
  endtask

  task automatic check_window(input logic [63:0] pc);
    @(negedge clk);
    PC = pc;
    #1;
    compare_now();
  endtask

  task automatic write_byte(input logic [63:0] a, input logic [7:0] d);
    @(negedge clk);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    if (a < 64'(N)) model[a[9:0]] = d;
  endtask

  logic [7:0]  pat [10];
  logic [63:0] ra;

  initial begin
    pat = '{8'h30, 8'hF3, 8'h88, 8'h77, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    rst_n = 1'b0; PC = '0; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    model_reset();
    #23;
    @(negedge clk) rst_n = 1'b1;

    // Reset image
    check_window(64'd0);
    check_window(64'd1);

    // Program load of bytes 100..109
    for (int i = 0; i < 10; i++) write_byte(64'd100 + 64'(i), pat[i]);
    check_window(64'd100);
    check_window(64'd95);

    // Boundary: populate the top of memory, then probe around the edge
    write_byte(64'd1023, 8'hEE);
    write_byte(64'd1020, 8'h5C);
    write_byte(64'd1015, 8'h7A);
    check_window(64'd1014);
    check_window(64'd1015);
    check_window(64'd1016);
    check_window(64'hFFFF_FFFF_FFFF_FFFF);
    check_window(64'h8000_0000_0000_0000);

    // Out-of-range writes are ignored (incl. ones whose low bits alias)
    write_byte(64'd1024, 8'hAB);
    write_byte(64'h8000_0000_0000_0005, 8'hCD);
    write_byte(64'h0000_0001_0000_03FF, 8'h99);
    check_window(64'd1014);
    check_window(64'd0);

    // Read during write: old byte before the edge, new byte after it
    @(negedge clk);
    PC = 64'd100; wr_en = 1'b1; wr_addr = 64'd103; wr_data = 8'h5A;
    #1;
    compare_now();
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[103] = 8'h5A;
    compare_now();

    // Random load and fetch against the model
    for (int i = 0; i < 300; i++) begin
      ra = ($urandom_range(0, 7) == 0) ? {$urandom, $urandom} | 64'd1024
                                       : 64'($urandom_range(0, N - 1));
      write_byte(ra, 8'($urandom));
    end
    for (int i = 0; i < 80; i++) begin
      ra = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom}
                                       : 64'($urandom_range(0, N - 8));
      check_window(ra);
    end

    // Mid-load reset wipes loaded bytes immediately and blocks writes
    write_byte(64'd5, 8'hAA);
    check_window(64'd0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    compare_now();
    wr_en = 1'b1; wr_addr = 64'd6; wr_data = 8'h55;
    @(posedge clk);
    #1;
    compare_now();

    // First edge after reset release accepts the pending write
    @(negedge clk);
    rst_n = 1'b1; wr_addr = 64'd7; wr_data = 8'h77;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    model[7] = 8'h77;
    compare_now();
    check_window(64'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instruction_memory.md
INSTRUCTION_MEMORY -- requirements
Module: instruction_memory

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024; it sets the number of byte locations.
REQ-002 The block SHALL have port clk, input, 1 bit; it is the single clock, and all writes occur on its rising edge.
REQ-003 The block SHALL have port rst_n, input, 1 bit; it is the reset, asynchronous and active-low.
REQ-004 The block SHALL have port PC, input, 64 bits; it is the fetch byte address.
REQ-005 The block SHALL have port wr_en, input, 1 bit; it is the program-load byte write enable.
REQ-006 The block SHALL have port wr_addr, input, 64 bits; it is the program-load byte address.
REQ-007 The block SHALL have port wr_data, input, 8 bits; it is the program-load byte data.
REQ-008 The block SHALL have ports im_out0 through im_out9, outputs, 8 bits each; im_outK is the byte at address PC+K.
REQ-009 The block SHALL have port imem_error, output, 1 bit; it flags a fetch window that is out of range.

Function
REQ-010 The memory SHALL be byte-addressable, little-endian, with MEM_BYTES locations at addresses 0..MEM_BYTES-1.
REQ-011 Reads SHALL be combinational: im_out0..9 and imem_error follow PC with zero clock latency.
REQ-012 imem_error SHALL be 1 exactly when PC > MEM_BYTES-10 (any of the 10 bytes lies out of range).
- The comparison is full 64-bit unsigned with no wrap, so PC near 2^64-1 flags an error.
REQ-013 While imem_error=1, all of im_out0..9 SHALL read 8'h00 (the halt opcode).
- No partial windows are returned.
REQ-014 At PC = MEM_BYTES-10 (the boundary), the block SHALL set imem_error=0 and return valid bytes.
REQ-015 On a rising clk edge with wr_en=1 and wr_addr < MEM_BYTES, the block SHALL write wr_data to mem[wr_addr].
REQ-016 A write with wr_addr >= MEM_BYTES SHALL be silently ignored; no state changes.
REQ-017 Read-during-write to an address in the current window SHALL return the old byte before the edge and the new byte after it; there is no bypass.
REQ-018 The block SHALL contain no other state; imem_error depends only on PC.

Reset
REQ-019 While rst_n=0, all locations SHALL be forced to their reset image, asynchronously, and writes SHALL be blocked.
REQ-020 The default reset image SHALL be all bytes 8'h00.
REQ-021 If rst_n is asserted in the middle of a program load, all previously loaded bytes SHALL be lost.
REQ-022 The first write after reset SHALL be accepted on the first rising edge with rst_n=1.

Configuration
REQ-023 Macro IMEM_PRELOAD_EN SHALL select the reset image.
- Defined: the reset image is bytes 0..9 = 30 F0 10 00 00 00 00 00 00 00 (irmovq $0x10,%rax), byte 10 = 00 (halt), and all remaining bytes = 00.
- Undefined: the reset image is all zeros per REQ-020.
- Write behaviour is identical in both builds.

Structure
REQ-024 A shared package SHALL hold the following:
- MEM_BYTES_DEFAULT = 1024
- FETCH_BYTES = 10
- OP_HALT = 8'h00
- the IMEM_PRELOAD_EN image bytes as constants
REQ-025 Storage SHALL live in one sub-module, imem_storage.
- It contains the byte array, the async reset and the write port.
- The top level holds the 10-byte read window, the range check and the error masking.

Verification
REQ-026 Reset with the macro undefined, then PC=0 -> im_out0..9 = 00, imem_error=0.
REQ-027 Write bytes 100..109 = 30 F3 88 77 66 55 44 33 22 11, then PC=100 -> im_out0=30, im_out1=F3, im_out2=88, im_out9=11, imem_error=0.
REQ-028 Boundary check with MEM_BYTES=1024:
- PC=1014 -> imem_error=0.
- PC=1015 -> imem_error=1 and all outputs 00.
- PC=64'hFFFF_FFFF_FFFF_FFFF -> imem_error=1.
REQ-029 Write to wr_addr=1024 with data AB -> no location changes; a read at PC=1014 is unaffected.
REQ-030 Load byte 5=AA, assert rst_n=0 mid-cycle -> im_out5 at PC=0 immediately reads 00 (or 00 under IMEM_PRELOAD_EN, per the image).
REQ-031 Macro defined, reset, PC=0 -> im_out0=30, im_out1=F0, im_out2=10; PC=1 -> im_out9=00 (byte 10, halt).
